col_collector: RTL and testbench

Receiving end of the second-layer scheduler's column output stream. After each start pulse, it captures two serialized result columns of `ROWS` words each, one per lane, and stores them into a `ROWS x COLS` output matrix indexed by column index. It tracks which columns are complete and exposes a registered random-access read port for the downstream stage.

---
 rtl/col_collector_if.sv | 34 +++
 rtl/col_collector.sv | 111 +++++++++++
 tb/tb_col_collector.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/col_collector_if.sv
// Port bundle for col_collector: capture stream, clear, read port and status.
interface col_collector_if #(
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned IDX_BITS  = 3,
  parameter int unsigned COLS      = 8
);
  logic                 i_result;
  logic [DATA_BITS-1:0] i_col_1;
  logic [IDX_BITS-1:0]  i_col_idx_1;
  logic [DATA_BITS-1:0] i_col_2;
  logic [IDX_BITS-1:0]  i_col_idx_2;
  logic                 i_clear;
  logic                 i_rd_en;
  logic [IDX_BITS-1:0]  i_rd_col;
  logic [7:0]           i_rd_row;
  logic [DATA_BITS-1:0] o_rd_data;
  logic                 o_rd_valid;
  logic                 o_busy;
  logic [COLS-1:0]      o_col_done;
  logic                 o_all_done;
  logic                 o_err;

  modport master (
    output i_result, i_col_1, i_col_idx_1, i_col_2, i_col_idx_2,
           i_clear, i_rd_en, i_rd_col, i_rd_row,
    input  o_rd_data, o_rd_valid, o_busy, o_col_done, o_all_done, o_err
  );

  modport slave (
    input  i_result, i_col_1, i_col_idx_1, i_col_2, i_col_idx_2,
           i_clear, i_rd_en, i_rd_col, i_rd_row,
    output o_rd_data, o_rd_valid, o_busy, o_col_done, o_all_done, o_err
  );
endinterface

// File: rtl/col_collector.sv
// Captures two serialized result columns per start pulse into a ROWS x COLS
// matrix, tracks completed columns and serves a registered read port.
module col_collector #(
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned ROWS      = 100,
  parameter int unsigned COLS      = 8,
  parameter int unsigned IDX_BITS  = 3
) (
  input logic            clk,
  input logic            rst,
  col_collector_if.slave bus
);
  localparam int unsigned ADDR_BITS = $clog2(COLS * ROWS);
  localparam logic [7:0]  LAST_ROW  = 8'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, LANE1, LANE2} state_t;

  state_t               state, state_next;
  logic [7:0]           row_cnt;
  logic [IDX_BITS-1:0]  idx1, idx2;
  logic [DATA_BITS-1:0] mem [COLS*ROWS];
  logic [COLS-1:0]      col_done;
  logic                 err;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid;

  logic                 we;
  logic [IDX_BITS-1:0]  widx;
  logic [DATA_BITS-1:0] wdata;
  logic                 last;
  logic                 err_set;
  logic [COLS-1:0]      done_set;
  logic                 rd_oob;
  logic [ADDR_BITS-1:0] waddr, raddr;

  assign last  = (row_cnt == LAST_ROW);
  assign waddr = ADDR_BITS'(widx) * ADDR_BITS'(ROWS) + ADDR_BITS'(row_cnt);
  assign raddr = ADDR_BITS'(bus.i_rd_col) * ADDR_BITS'(ROWS) + ADDR_BITS'(bus.i_rd_row);

  always_comb begin
    state_next = state;
    we         = 1'b0;
    widx       = idx1;
    wdata      = bus.i_col_1;
    err_set    = 1'b0;
    done_set   = '0;
    rd_oob     = bus.i_rd_en && (32'(bus.i_rd_row) >= ROWS);
    case (state)
      IDLE: if (bus.i_result) state_next = LANE1;
      LANE1: begin
        we   = 1'b1;
        // Word 0 carries the column index; later words reuse the latched copy.
        widx = (row_cnt == '0) ? bus.i_col_idx_1 : idx1;
        if (row_cnt != '0 && bus.i_col_idx_1 != idx1) err_set = 1'b1;
        if (last) begin
          done_set[widx] = 1'b1;
          state_next     = LANE2;
        end
      end
      LANE2: begin
        we    = 1'b1;
        wdata = bus.i_col_2;
        widx  = (row_cnt == '0) ? bus.i_col_idx_2 : idx2;
        if (row_cnt == '0 && bus.i_col_idx_2 == idx1) err_set = 1'b1;
        if (row_cnt != '0 && bus.i_col_idx_2 != idx2) err_set = 1'b1;
        if (last) begin
          done_set[widx] = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state != IDLE && bus.i_result) err_set = 1'b1;
    if (rd_oob) err_set = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      row_cnt  <= '0;
      idx1     <= '0;
      idx2     <= '0;
      col_done <= '0;
      err      <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE || last) row_cnt <= '0;
      else                       row_cnt <= row_cnt + 8'd1;
      if (state == LANE1 && row_cnt == '0) idx1 <= bus.i_col_idx_1;
      if (state == LANE2 && row_cnt == '0) idx2 <= bus.i_col_idx_2;
      // Setting a flag takes priority over a simultaneous clear.
      col_done <= (col_done & ~{COLS{bus.i_clear}}) | done_set;
      err      <= (err & ~bus.i_clear) | err_set;
      rd_valid <= bus.i_rd_en;
      if (bus.i_rd_en) rd_data <= rd_oob ? '0 : mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign bus.o_rd_data  = rd_data;
  assign bus.o_rd_valid = rd_valid;
  assign bus.o_busy     = (state != IDLE);
  assign bus.o_col_done = col_done;
  assign bus.o_all_done = &col_done;
  assign bus.o_err      = err;
endmodule

// File: tb/tb_col_collector.sv
// Directed bench for col_collector: capture, full matrix, errors, reset, reads.
module tb_col_collector;
  localparam int ROWS = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  col_collector_if #(.DATA_BITS(16), .IDX_BITS(3), .COLS(8)) b ();

  col_collector #(.DATA_BITS(16), .ROWS(100), .COLS(8), .IDX_BITS(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_mem [8][ROWS];

  int bad_word        = -1;
  int bad_idx         = 0;
  int busy_start_word = -1;
  int probe_word      = -1;
  bit clear_last      = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    b.i_clear = 1'b1;
    tick();
    b.i_clear = 1'b0;
  endtask

  task automatic do_read(input int col, input int row,
                         output logic [15:0] data, output logic valid);
    b.i_rd_en  = 1'b1;
    b.i_rd_col = 3'(col);
    b.i_rd_row = 8'(row);
    tick();
    b.i_rd_en  = 1'b0;
    data  = b.o_rd_data;
    valid = b.o_rd_valid;
  endtask

  task automatic capture(input int idx1, input int idx2, input int base1, input int base2,
                         output logic [7:0] done_pre, output logic [7:0] done_l1,
                         output logic err_l1, output logic err_l2,
                         output logic [15:0] probe_data);
    probe_data = '0;
    done_pre   = '0;
    err_l2     = 1'b0;
    b.i_result = 1'b1;
    tick();
    b.i_result = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      b.i_col_1     = 16'(base1 + r);
      b.i_col_idx_1 = (bad_word >= 0 && r >= bad_word) ? 3'(bad_idx) : 3'(idx1);
      b.i_col_2     = '0;
      b.i_col_idx_2 = '0;
      if (r == probe_word) begin
        b.i_rd_en  = 1'b1;
        b.i_rd_col = 3'(idx1);
        b.i_rd_row = 8'(r);
      end
      tick();
      if (r == probe_word) begin
        b.i_rd_en  = 1'b0;
        probe_data = b.o_rd_data;
      end
      if (r == ROWS - 2) done_pre = b.o_col_done;
      exp_mem[idx1][r] = base1 + r;
    end
    done_l1 = b.o_col_done;
    err_l1  = b.o_err;
    for (int r = 0; r < ROWS; r++) begin
      b.i_col_1     = '0;
      b.i_col_idx_1 = '0;
      b.i_col_2     = 16'(base2 + r);
      b.i_col_idx_2 = 3'(idx2);
      b.i_result    = (r == busy_start_word);
      b.i_clear     = clear_last && (r == ROWS - 1);
      tick();
      if (r == 0) err_l2 = b.o_err;
      exp_mem[idx2][r] = base2 + r;
    end
    b.i_result    = 1'b0;
    b.i_clear     = 1'b0;
    b.i_col_2     = '0;
    b.i_col_idx_2 = '0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({b.o_rd_data, b.o_rd_valid, b.o_busy, b.o_col_done, b.o_all_done, b.o_err} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%0h valid=%0b busy=%0b done=%b all=%0b err=%0b, want all 0",
               b.o_rd_data, b.o_rd_valid, b.o_busy, b.o_col_done, b.o_all_done, b.o_err);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (b.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%0b want 0", b.o_busy);
    end
  endtask

  task automatic test_basic_capture();
    logic [7:0] dpre, dl1;
    logic el1, el2, v;
    logic [15:0] pd, d;
    b.i_result = 1'b1;
    tick();
    b.i_result = 1'b0;
    n_checks++;
    if (b.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_start: busy=%0b want 1", b.o_busy);
    end
    // Finish this first stream by hand so the start-to-busy edge is checked above.
    for (int r = 0; r < ROWS; r++) begin
      b.i_col_1 = 16'(r); b.i_col_idx_1 = 3'd2; tick();
      if (r == ROWS - 2) dpre = b.o_col_done;
    end
    dl1 = b.o_col_done;
    for (int r = 0; r < ROWS; r++) begin
      b.i_col_1 = '0; b.i_col_idx_1 = '0;
      b.i_col_2 = 16'(1000 + r); b.i_col_idx_2 = 3'd5; tick();
    end
    for (int r = 0; r < ROWS; r++) begin exp_mem[2][r] = r; exp_mem[5][r] = 1000 + r; end
    n_checks++;
    if (dpre !== 8'h00) begin
      n_fail++; $display("FAIL basic_done_early: done=%b want 00000000", dpre);
    end
    n_checks++;
    if (dl1 !== 8'b0000_0100) begin
      n_fail++; $display("FAIL basic_done_lane1: done=%b want 00000100", dl1);
    end
    n_checks++;
    if (b.o_col_done !== 8'b0010_0100 || b.o_busy !== 1'b0 || b.o_err !== 1'b0 || b.o_all_done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end: done=%b busy=%0b err=%0b all=%0b want 00100100 0 0 0",
               b.o_col_done, b.o_busy, b.o_err, b.o_all_done);
    end
    do_read(2, 37, d, v);
    n_checks++;
    if (d !== 16'd37 || v !== 1'b1) begin
      n_fail++; $display("FAIL basic_read_2_37: data=%0d valid=%0b want 37 1", d, v);
    end
    do_read(5, 99, d, v);
    n_checks++;
    if (d !== 16'd1099 || v !== 1'b1) begin
      n_fail++; $display("FAIL basic_read_5_99: data=%0d valid=%0b want 1099 1", d, v);
    end
    tick();
    n_checks++;
    if (b.o_rd_valid !== 1'b0 || b.o_rd_data !== 16'd1099) begin
      n_fail++; $display("FAIL basic_read_idle: valid=%0b data=%0d want 0 1099", b.o_rd_valid, b.o_rd_data);
    end
    pd = '0; el1 = 0; el2 = 0;
  endtask

  task automatic test_full_matrix();
    logic [7:0] dpre, dl1;
    logic el1, el2, v;
    logic [15:0] pd, d;
    do_clear();
    for (int p = 0; p < 4; p++) begin
      capture(2 * p, 2 * p + 1, (2 * p) * 1000 + 500, (2 * p + 1) * 1000 + 500, dpre, dl1, el1, el2, pd);
      n_checks++;
      if (b.o_all_done !== (p == 3)) begin
        n_fail++; $display("FAIL full_all_done_%0d: all=%0b want %0b", p, b.o_all_done, p == 3);
      end
    end
    n_checks++;
    if (b.o_err !== 1'b0 || b.o_col_done !== 8'hff) begin
      n_fail++; $display("FAIL full_flags: err=%0b done=%b want 0 11111111", b.o_err, b.o_col_done);
    end
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < ROWS; r++) begin
        do_read(c, r, d, v);
        n_checks++;
        if (d !== 16'(exp_mem[c][r]) || v !== 1'b1) begin
          n_fail++;
          $display("FAIL full_read_%0d_%0d: data=%0d valid=%0b want %0d 1", c, r, d, v, exp_mem[c][r]);
        end
      end
  endtask

  task automatic test_protocol_errors();
    logic [7:0] dpre, dl1;
    logic el1, el2, v;
    logic [15:0] pd, d;
    do_clear();
    bad_word = 50; bad_idx = 4;
    capture(3, 0, 20000, 21000, dpre, dl1, el1, el2, pd);
    bad_word = -1;
    n_checks++;
    if (el1 !== 1'b1 || dl1 !== 8'b0000_1000) begin
      n_fail++; $display("FAIL idx_change_flags: err=%0b done=%b want 1 00001000", el1, dl1);
    end
    do_read(3, 50, d, v);
    n_checks++;
    if (d !== 16'd20050) begin
      n_fail++; $display("FAIL idx_change_col3_50: data=%0d want 20050", d);
    end
    do_read(3, 99, d, v);
    n_checks++;
    if (d !== 16'd20099) begin
      n_fail++; $display("FAIL idx_change_col3_99: data=%0d want 20099", d);
    end
    do_read(4, 50, d, v);
    n_checks++;
    if (d !== 16'(exp_mem[4][50])) begin
      n_fail++; $display("FAIL idx_change_col4_untouched: data=%0d want %0d", d, exp_mem[4][50]);
    end

    do_clear();
    busy_start_word = 10;
    capture(1, 2, 22000, 23000, dpre, dl1, el1, el2, pd);
    busy_start_word = -1;
    n_checks++;
    if (el1 !== 1'b0 || b.o_err !== 1'b1 || b.o_col_done !== 8'b0000_0110 || b.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_while_busy: err_l1=%0b err=%0b done=%b busy=%0b want 0 1 00000110 0",
               el1, b.o_err, b.o_col_done, b.o_busy);
    end
    do_read(2, 99, d, v);
    n_checks++;
    if (d !== 16'd23099) begin
      n_fail++; $display("FAIL start_while_busy_data: data=%0d want 23099", d);
    end
  endtask

  task automatic test_duplicate_index();
    logic [7:0] dpre, dl1;
    logic el1, el2, v;
    logic [15:0] pd, d;
    do_clear();
    capture(6, 6, 3000, 4000, dpre, dl1, el1, el2, pd);
    n_checks++;
    if (el1 !== 1'b0 || el2 !== 1'b1) begin
      n_fail++; $display("FAIL dup_err_timing: err_l1=%0b err_l2=%0b want 0 1", el1, el2);
    end
    n_checks++;
    if (b.o_col_done !== 8'b0100_0000) begin
      n_fail++; $display("FAIL dup_done: done=%b want 01000000", b.o_col_done);
    end
    do_read(6, 0, d, v);
    n_checks++;
    if (d !== 16'd4000) begin
      n_fail++; $display("FAIL dup_data_6_0: data=%0d want 4000", d);
    end
    do_read(6, 99, d, v);
    n_checks++;
    if (d !== 16'd4099) begin
      n_fail++; $display("FAIL dup_data_6_99: data=%0d want 4099", d);
    end
  endtask

  task automatic test_reset_mid_capture();
    logic [7:0] dpre, dl1;
    logic el1, el2, v;
    logic [15:0] pd, d;
    b.i_result = 1'b1;
    tick();
    b.i_result = 1'b0;
    for (int r = 0; r < 60; r++) begin
      b.i_col_1 = 16'(30000 + r); b.i_col_idx_1 = 3'd5; tick();
    end
    n_checks++;
    if (b.o_busy !== 1'b1 || b.o_err !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: busy=%0b err=%0b want 1 1", b.o_busy, b.o_err);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({b.o_rd_data, b.o_rd_valid, b.o_busy, b.o_col_done, b.o_all_done, b.o_err} !== 28'h0) begin
      n_fail++;
      $display("FAIL rst_mid_async: data=%0h valid=%0b busy=%0b done=%b all=%0b err=%0b want all 0",
               b.o_rd_data, b.o_rd_valid, b.o_busy, b.o_col_done, b.o_all_done, b.o_err);
    end
    b.i_col_1 = '0; b.i_col_idx_1 = '0;
    tick();
    rst = 1'b0;
    tick();
    capture(0, 7, 31000, 32000, dpre, dl1, el1, el2, pd);
    n_checks++;
    if (b.o_col_done !== 8'b1000_0001 || b.o_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_recapture: done=%b err=%0b want 10000001 0", b.o_col_done, b.o_err);
    end
    do_read(0, 0, d, v);
    n_checks++;
    if (d !== 16'd31000) begin
      n_fail++; $display("FAIL rst_mid_data_0_0: data=%0d want 31000", d);
    end
    do_read(7, 99, d, v);
    n_checks++;
    if (d !== 16'd32099) begin
      n_fail++; $display("FAIL rst_mid_data_7_99: data=%0d want 32099", d);
    end
  endtask

  task automatic test_read_edges();
    logic [7:0] dpre, dl1;
    logic el1, el2, v;
    logic [15:0] pd, d;
    int old;
    old = exp_mem[1][20];
    probe_word = 20;
    capture(1, 3, 40000, 42000, dpre, dl1, el1, el2, pd);
    probe_word = -1;
    n_checks++;
    if (pd !== 16'(old)) begin
      n_fail++; $display("FAIL rw_same_cycle: data=%0d want old %0d", pd, old);
    end
    do_read(1, 20, d, v);
    n_checks++;
    if (d !== 16'd40020) begin
      n_fail++; $display("FAIL rw_after_write: data=%0d want 40020", d);
    end
    clear_last = 1'b1;
    capture(2, 4, 41000, 43000, dpre, dl1, el1, el2, pd);
    clear_last = 1'b0;
    n_checks++;
    if (b.o_col_done !== 8'b0001_0000 || b.o_err !== 1'b0) begin
      n_fail++; $display("FAIL clear_at_done: done=%b err=%0b want 00010000 0", b.o_col_done, b.o_err);
    end
    do_read(0, 100, d, v);
    n_checks++;
    if (d !== 16'd0 || v !== 1'b1 || b.o_err !== 1'b1) begin
      n_fail++; $display("FAIL read_oob: data=%0d valid=%0b err=%0b want 0 1 1", d, v, b.o_err);
    end
  endtask

  initial begin
    b.i_result = 1'b0; b.i_col_1 = '0; b.i_col_idx_1 = '0; b.i_col_2 = '0;
    b.i_col_idx_2 = '0; b.i_clear = 1'b0; b.i_rd_en = 1'b0; b.i_rd_col = '0; b.i_rd_row = '0;
    test_reset();
    test_basic_capture();
    test_full_matrix();
    test_protocol_errors();
    test_duplicate_index();
    test_reset_mid_capture();
    test_read_edges();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
